// File: rtl/gpio_fnmux_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : gpio_fnmux_pkg
//  Purpose  : Shared constants for the function-muxed GPIO pad controller:
//             register byte offsets, FNSEL field geometry, the idle level
//             presented on fn_i, and a byte-lane mask helper.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package gpio_fnmux_pkg;

  // Register byte offsets (only address bits [7:2] are decoded)
  localparam logic [7:0] OFF_ID         = 8'h00;
  localparam logic [7:0] OFF_GPIO_OUT   = 8'h04;
  localparam logic [7:0] OFF_GPIO_OE    = 8'h08;
  localparam logic [7:0] OFF_GPIO_IN    = 8'h0C;
  localparam logic [7:0] OFF_RISE_EN    = 8'h10;
  localparam logic [7:0] OFF_FALL_EN    = 8'h14;
  localparam logic [7:0] OFF_IRQ_STAT   = 8'h18;
  localparam logic [7:0] OFF_FILT_EN    = 8'h1C;
  localparam logic [5:0] FNSEL_BASE_IDX = 6'd8;   // word index of FNSEL_0

  // FNSEL geometry: 4-bit field per pad, 8 pads per 32-bit register
  localparam int FNSEL_W       = 4;
  localparam int FNSEL_PER_REG = 8;

  typedef logic [FNSEL_W-1:0] fnsel_t;

  // Level seen by a peripheral when its pad is not routed to it; high is
  // the idle state for UART RX and I2C lines.
  localparam logic FN_I_IDLE = 1'b1;

  function automatic logic [31:0] lane_mask(input logic [3:0] sel);
    return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
  endfunction

endpackage
`default_nettype wire

// File: rtl/gpio_fnmux_infilt.sv
`default_nettype none
// ============================================================================
//  Module   : gpio_infilt
//  Purpose  : One pad's GPIO input path: multi-stage synchroniser, optional
//             debounce filter and registered edge detector.
//  Ports    : clk, rst      - clock, asynchronous active-high reset
//             pad_i         - raw asynchronous pad input
//             filt_en       - debounce enable for this pad
//             f             - filtered input level
//             rise / fall   - single-cycle edge indications on f
//  Revision : 1.0 - initial release
// ============================================================================
module gpio_infilt #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_W      = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic pad_i,
  input  logic filt_en,
  output logic f,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [FILT_W-1:0]      r_cnt;
  logic                   r_f;
  logic                   r_f_d;
  logic                   w_s;

  assign w_s = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '0;
      r_cnt  <= '0;
      r_f    <= 1'b0;
      r_f_d  <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], pad_i};
      r_f_d  <= r_f;
      if (!filt_en) begin
        // Holding the counter at zero while disabled means any toggle of
        // filt_en starts the filter from a clean count.
        r_f   <= w_s;
        r_cnt <= '0;
      end else if (w_s == r_f) begin
        r_cnt <= '0;
      end else if (r_cnt == '1) begin
        r_f   <= w_s;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign f    = r_f;
  assign rise = r_f & ~r_f_d;
  assign fall = ~r_f & r_f_d;

endmodule
`default_nettype wire

// File: rtl/gpio_fnmux.sv
`default_nettype none
// ============================================================================
//  Module   : gpio_fnmux
//  Purpose  : Pad controller selecting, per pad, GPIO (function 0) or one of
//             NFN-1 peripheral functions. Holds GPIO out/OE/in registers,
//             debounced inputs and edge-triggered interrupt status behind a
//             classic Wishbone slave.
//  Ports    : clk, rst              - clock, asynchronous active-high reset
//             wb_*                  - Wishbone slave (wb_dat_i = read data out,
//                                     wb_dat_o = write data in)
//             fn_o / fn_oe          - peripheral outputs, index p*NFN+f
//             fn_i                  - peripheral inputs, one per pad
//             pad_o / pad_oe / pad_i- IO bank pad signals
//             irq                   - level interrupt
//  Revision : 1.0 - initial release
// ============================================================================
module gpio_fnmux
  import gpio_fnmux_pkg::*;
#(
  parameter int          NPADS       = 22,
  parameter int          NFN         = 4,
  parameter int          SYNC_STAGES = 2,
  parameter int          FILT_W      = 4,
  parameter logic [15:0] SYSINFO     = 16'h0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          wb_adr,
  output logic [31:0]          wb_dat_i,
  input  logic [31:0]          wb_dat_o,
  input  logic                 wb_we,
  input  logic [3:0]           wb_sel,
  input  logic                 wb_stb,
  input  logic                 wb_cyc,
  output logic                 wb_ack,
  input  logic [NPADS*NFN-1:0] fn_o,
  input  logic [NPADS*NFN-1:0] fn_oe,
  output logic [NPADS-1:0]     fn_i,
  output logic [NPADS-1:0]     pad_o,
  output logic [NPADS-1:0]     pad_oe,
  input  logic [NPADS-1:0]     pad_i,
  output logic                 irq
);

  localparam int         NFNSEL    = (NPADS + FNSEL_PER_REG - 1) / FNSEL_PER_REG;
  localparam logic [5:0] NFNSEL_W6 = 6'(NFNSEL);

  logic [NPADS-1:0]         r_gpio_out, r_gpio_oe, r_rise_en, r_fall_en;
  logic [NPADS-1:0]         r_irq_stat, r_filt_en;
  logic [NPADS*FNSEL_W-1:0] r_fnsel;
  logic                     r_ack, r_irq;
  logic [31:0]              r_rdata;

  logic                     w_req, w_wr, w_fn_hit;
  logic [7:0]               w_off;
  logic [5:0]               w_fn_idx;
  logic [31:0]              w_lmask, w_rdata;
  logic [NPADS-1:0]         w_pmask, w_wd, w_w1c, w_set;
  logic [NPADS-1:0]         w_gpio_in, w_rise, w_fall;
  logic [NFNSEL*32-1:0]     w_fnsel_win;

  // A new request is only taken while ack is low, giving one ack per two cycles.
  assign w_req    = wb_cyc & wb_stb & ~r_ack;
  assign w_wr     = w_req & wb_we;
  assign w_off    = {wb_adr[7:2], 2'b00};
  assign w_fn_idx = wb_adr[7:2] - FNSEL_BASE_IDX;
  assign w_fn_hit = (wb_adr[7:2] >= FNSEL_BASE_IDX) && (w_fn_idx < NFNSEL_W6);
  assign w_lmask  = lane_mask(wb_sel);
  assign w_pmask  = w_lmask[NPADS-1:0];
  assign w_wd     = wb_dat_o[NPADS-1:0];
  assign w_w1c    = (w_wr && w_off == OFF_IRQ_STAT) ? (w_wd & w_pmask) : '0;
  assign w_set    = (w_rise & r_rise_en) | (w_fall & r_fall_en);

  // FNSEL fields of pads that do not exist read back as zero.
  always_comb begin
    w_fnsel_win = '0;
    w_fnsel_win[NPADS*FNSEL_W-1:0] = r_fnsel;
  end

  always_comb begin
    w_rdata = '0;
    case (w_off)
      OFF_ID:       w_rdata = {8'(NFN), 8'(NPADS), SYSINFO};
      OFF_GPIO_OUT: w_rdata[NPADS-1:0] = r_gpio_out;
      OFF_GPIO_OE:  w_rdata[NPADS-1:0] = r_gpio_oe;
      OFF_GPIO_IN:  w_rdata[NPADS-1:0] = w_gpio_in;
      OFF_RISE_EN:  w_rdata[NPADS-1:0] = r_rise_en;
      OFF_FALL_EN:  w_rdata[NPADS-1:0] = r_fall_en;
      OFF_IRQ_STAT: w_rdata[NPADS-1:0] = r_irq_stat;
      OFF_FILT_EN:  w_rdata[NPADS-1:0] = r_filt_en;
      default: begin
        for (int k = 0; k < NFNSEL; k++) begin
          if (w_fn_hit && w_fn_idx == 6'(k)) w_rdata = w_fnsel_win[k*32 +: 32];
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ack      <= 1'b0;
      r_rdata    <= '0;
      r_irq      <= 1'b0;
      r_gpio_out <= '0;
      r_gpio_oe  <= '0;
      r_rise_en  <= '0;
      r_fall_en  <= '0;
      r_irq_stat <= '0;
      r_filt_en  <= '0;
      r_fnsel    <= '0;
    end else begin
      r_ack   <= w_req;
      r_rdata <= w_req ? w_rdata : '0;
      r_irq   <= |r_irq_stat;
      // A new event in the same cycle as a clearing write keeps the bit set.
      r_irq_stat <= (r_irq_stat & ~w_w1c) | w_set;
      if (w_wr) begin
        case (w_off)
          OFF_GPIO_OUT: r_gpio_out <= (r_gpio_out & ~w_pmask) | (w_wd & w_pmask);
          OFF_GPIO_OE:  r_gpio_oe  <= (r_gpio_oe  & ~w_pmask) | (w_wd & w_pmask);
          OFF_RISE_EN:  r_rise_en  <= (r_rise_en  & ~w_pmask) | (w_wd & w_pmask);
          OFF_FALL_EN:  r_fall_en  <= (r_fall_en  & ~w_pmask) | (w_wd & w_pmask);
          OFF_FILT_EN:  r_filt_en  <= (r_filt_en  & ~w_pmask) | (w_wd & w_pmask);
          default: ;
        endcase
      end
      // Each 4-bit field sits inside one byte lane (two fields per lane).
      for (int p = 0; p < NPADS; p++) begin
        if (w_wr && w_fn_hit && w_fn_idx == 6'(p / FNSEL_PER_REG) &&
            wb_sel[(p % FNSEL_PER_REG) / 2]) begin
          r_fnsel[p*FNSEL_W +: FNSEL_W] <= wb_dat_o[(p % FNSEL_PER_REG)*FNSEL_W +: FNSEL_W];
        end
      end
    end
  end

  assign wb_ack   = r_ack;
  assign wb_dat_i = r_rdata;
  assign irq      = r_irq;

  generate
    for (genvar p = 0; p < NPADS; p++) begin : g_pad
      fnsel_t w_sel;
      logic   w_po, w_poe, w_fi;

      assign w_sel = r_fnsel[p*FNSEL_W +: FNSEL_W];

      always_comb begin
        w_po  = r_gpio_out[p];
        w_poe = r_gpio_oe[p];
        w_fi  = FN_I_IDLE;
        if (w_sel != '0) begin
          // Selections beyond the implemented functions park the pad tristated.
          w_po  = 1'b0;
          w_poe = 1'b0;
          for (int f = 1; f < NFN; f++) begin
            if (w_sel == fnsel_t'(f)) begin
              w_po  = fn_o[p*NFN+f];
              w_poe = fn_oe[p*NFN+f];
              w_fi  = pad_i[p];
            end
          end
        end
      end

      assign pad_o[p]  = w_po;
      assign pad_oe[p] = w_poe;
      assign fn_i[p]   = w_fi;

      gpio_infilt #(
        .SYNC_STAGES(SYNC_STAGES),
        .FILT_W     (FILT_W)
      ) u_infilt (
        .clk    (clk),
        .rst    (rst),
        .pad_i  (pad_i[p]),
        .filt_en(r_filt_en[p]),
        .f      (w_gpio_in[p]),
        .rise   (w_rise[p]),
        .fall   (w_fall[p])
      );
    end
  endgenerate

  // Address bits outside [7:2], function-0 slots of fn_o/fn_oe and lane
  // bits above NPADS carry no meaning here.
  logic unused_bits;
  assign unused_bits = ^{wb_adr[31:8], wb_adr[1:0], fn_o, fn_oe, w_lmask, wb_dat_o};

endmodule
`default_nettype wire

// File: doc/gpio_fnmux.md
Name: gpio_fnmux

Overview:
- Parametrised second-generation pad controller for the muxed IO bank.
- Replaces the fixed primary/secondary function split with N selectable functions per pad, plus the GPIO.
- Owns GPIO output/OE/input registers, input synchronisation, optional per-pad debounce, and edge-triggered GPIO interrupts.
- Sits between the Wishbone bus, the peripheral function signals, and the muxed IO bank pad signals.

Parameters:
- NPADS, 22, number of muxed pads (1..32).
- NFN, 4, functions per pad including GPIO as function 0 (2..16).
- SYNC_STAGES, 2, input synchroniser depth on the GPIO input path (>=2).
- FILT_W, 4, debounce counter width; a value is accepted after 2^FILT_W-1 stable cycles.
- SYSINFO, 16'h0, value returned in the ID register.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- wb_adr  in  32  byte address; bits [7:2] decoded.
- wb_dat_i  out  32  read data.
- wb_dat_o  in  32  write data.
- wb_we  in  1  write enable.
- wb_sel  in  4  byte lane enables.
- wb_stb  in  1  strobe.
- wb_cyc  in  1  cycle.
- wb_ack  out  1  acknowledge.
- fn_o  in  NPADS*NFN  function output, index p*NFN+f; f=0 slots unused.
- fn_oe  in  NPADS*NFN  function output enable, same indexing.
- fn_i  out  NPADS  function input per pad.
- pad_o  out  NPADS  to IO bank.
- pad_oe  out  NPADS  to IO bank.
- pad_i  in  NPADS  from IO bank, asynchronous.
- irq  out  1  level interrupt, OR of enabled status bits.

Behaviour:
- Clock/reset: single clock clk; reset rst is asynchronous, active-high.
- Reset values: every register bit 0; wb_ack=0; wb_dat_i=0; irq=0; synchroniser and filter flops 0; all pads select function 0 with OE 0, so all pads are tristated.
- Wishbone (classic):
  - When wb_cyc&wb_stb&!wb_ack, wb_ack=1 on the next edge.
  - wb_ack drops the following cycle, so at most one ack per 2 cycles.
  - Read data is registered with the ack.
  - Writes are applied on the ack edge, per byte lane per wb_sel.
  - Unmapped addresses read 0, ignore writes, and are still acked.
- Register map (byte offsets; bits >= NPADS read 0 and ignore writes):
  - 0x00 ID (RO): {NFN[7:0], NPADS[7:0], SYSINFO}.
  - 0x04 GPIO_OUT (RW).
  - 0x08 GPIO_OE (RW).
  - 0x0C GPIO_IN (RO): filtered input.
  - 0x10 RISE_EN (RW).
  - 0x14 FALL_EN (RW).
  - 0x18 IRQ_STAT (W1C).
  - 0x1C FILT_EN (RW).
  - 0x20+4k FNSEL_k (RW): 4 bits per pad for pads 8k..8k+7, k < ceil(NPADS/8). Field bits above clog2(NFN) are stored as written.
- Mux, combinational from registers:
  - sel=0: pad_o=GPIO_OUT[p], pad_oe=GPIO_OE[p].
  - 0<sel<NFN: pad_o=fn_o[p*NFN+sel], pad_oe=fn_oe[p*NFN+sel].
  - sel>=NFN: pad_o=0, pad_oe=0.
- Function input:
  - fn_i[p]=pad_i[p] combinationally when 0<sel<NFN; the peripheral synchronises.
  - Otherwise fn_i[p]=1, the idle-high level safe for UART/I2C.
- GPIO input path:
  - pad_i passes through SYNC_STAGES flops to s[p].
  - FILT_EN[p]=0: filtered f[p] <= s[p] each cycle. Latency pad->GPIO_IN = SYNC_STAGES+1 cycles.
  - FILT_EN[p]=1: counter clears whenever s[p]==f[p], otherwise increments. At 2^FILT_W-1, f[p] <= s[p] and counter clears.
  - A glitch shorter than 2^FILT_W-1 cycles never reaches f.
  - Toggling FILT_EN clears that pad's counter.
- Edge detect on f, registered:
  - rise: f & ~f_d. fall: ~f & f_d.
  - IRQ_STAT[p] sets if (rise&RISE_EN)|(fall&FALL_EN).
  - A write of 1 clears the bit, except that a set in the same cycle as the W1C wins and the bit stays 1.
  - irq is registered: irq = |IRQ_STAT, one cycle after the status bit sets.
  - GPIO input/IRQ detection runs regardless of FNSEL.
- Reset mid-transaction: ack is dropped immediately; the pending write is lost.

Decomposition:
- Package gpio_fnmux_pkg holds:
  - register offset localparams;
  - FNSEL field width (4) and pads per FNSEL register (8);
  - the idle fn_i level constant.
- One sub-module, gpio_infilt: per-pad synchroniser + debounce counter + edge detector. It is instantiated NPADS times via generate.

Test Plan:
- Reset, then read 0x00 with SYSINFO=16'hBEEF, NPADS=22, NFN=4 -> 0x0416BEEF; pad_oe==0; fn_i all 1.
- Write FNSEL_0=0x0000_0020 (pad1 sel=2); drive fn_o[6]=1, fn_oe[6]=1 -> pad_o[1]=1, pad_oe[1]=1. Set pad1 sel=5 -> pad_o[1]=0, pad_oe[1]=0.
- GPIO_OE=0x1, GPIO_OUT with wb_sel=4'b0001 and data 0xFFFFFFFF -> GPIO_OUT reads 0x000000FF; pad_o[0]=1.
- FILT_EN[3]=1, FILT_W=4; pulse pad_i[3] high for 10 cycles -> GPIO_IN[3] stays 0. Hold high for 20 cycles -> GPIO_IN[3]=1 exactly SYNC_STAGES+15+1 cycles after the edge.
- RISE_EN[2]=1; raise pad_i[2] -> IRQ_STAT[2]=1, irq=1 next cycle. W1C 0x4 -> irq=0. W1C issued in the same cycle as a new rising edge -> bit remains 1.
- Assert rst during an in-flight write to GPIO_OUT -> wb_ack=0 immediately; GPIO_OUT reads 0 after release.
